// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the stepped MIPS pipeline: tracks post-ID destinations,
// picks forward sources, raises load-use stalls and IF/ID flushes. Optional stats: HAZARD_STATS_EN.
module hazard_scoreboard #(
    parameter int AW         = 5,
    parameter int STAGES     = 3,
    parameter int LOAD_READY = 2,
    parameter int SELW       = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic [AW-1:0]   id_dst,
    input  logic            id_wr,
    input  logic            id_load,
    input  logic            id_redirect,
    output logic            stall,
    output logic            flush_if,
    output logic [SELW-1:0] fwd_rs,
    output logic [SELW-1:0] fwd_rt
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt
`endif
);

    // Entry k mirrors the instruction currently in post-ID stage k (1 = EX).
    logic [STAGES:1] sb_valid;
    logic [STAGES:1] sb_load;
    logic [AW-1:0]   sb_dst [1:STAGES];

    logic haz_rs;
    logic haz_rt;
    logic enter_valid;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        fwd_rs = '0;
        fwd_rt = '0;
        haz_rs = 1'b0;
        haz_rt = 1'b0;
        // Scan oldest to youngest so the youngest producer overwrites older matches.
        for (int k = STAGES; k >= 1; k--) begin
            if (sb_valid[k] && sb_dst[k] == id_rs && id_rs != '0 && id_rs_used) begin
                fwd_rs = SELW'(k);
                haz_rs = sb_load[k] && (k < LOAD_READY);
            end
            if (sb_valid[k] && sb_dst[k] == id_rt && id_rt != '0 && id_rt_used) begin
                fwd_rt = SELW'(k);
                haz_rt = sb_load[k] && (k < LOAD_READY);
            end
        end
    end

    assign stall       = id_valid & (haz_rs | haz_rt);
    assign flush_if    = id_valid & id_redirect & ~stall;
    assign enter_valid = id_valid & id_wr & (id_dst != '0) & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
        if (rst) begin
            sb_valid <= '0;
        end else if (advance) begin
            sb_valid <= {sb_valid[STAGES-1:1], enter_valid};
        end
    end

    // NOTE: payload fields carry no reset; a cleared valid bit makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (advance) begin
            sb_load   <= {sb_load[STAGES-1:1], id_load};
            sb_dst[1] <= id_dst;
            for (int k = 2; k <= STAGES; k++) begin
                sb_dst[k] <= sb_dst[k-1];
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (advance) begin
            if (stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush_if && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`else
    // Statistics disabled: no counter registers exist in this build.
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard at default parameters
// (STAGES=3, LOAD_READY=2); counter checks are compiled in with HAZARD_STATS_EN.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst;
    logic       advance;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic [4:0] id_dst;
    logic       id_wr;
    logic       id_load;
    logic       id_redirect;
    logic       stall;
    logic       flush_if;
    logic [2:0] fwd_rs;
    logic [2:0] fwd_rt;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    hazard_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .advance     (advance),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .id_dst      (id_dst),
        .id_wr       (id_wr),
        .id_load     (id_load),
        .id_redirect (id_redirect),
        .stall       (stall),
        .flush_if    (flush_if),
        .fwd_rs      (fwd_rs),
        .fwd_rt      (fwd_rt)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic rs_u,
                          input logic [4:0] rt, input logic rt_u, input logic [4:0] dst,
                          input logic wr, input logic ld, input logic redir);
        id_valid    = v;
        id_rs       = rs;
        id_rs_used  = rs_u;
        id_rt       = rt;
        id_rt_used  = rt_u;
        id_dst      = dst;
        id_wr       = wr;
        id_load     = ld;
        id_redirect = redir;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
    endtask

    initial begin
        rst     = 1'b1;
        advance = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #10;
        check("rst_stall", stall, 0);
        check("rst_flush", flush_if, 0);
        check("rst_fwd_rs", fwd_rs, 0);
        check("rst_fwd_rt", fwd_rt, 0);
`ifdef HAZARD_STATS_EN
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
`endif
        #2 rst = 1'b0;
        step();

        // ALU chain: add $3; sub reads $3; nop; reader of $3 sees stage 3.
        set_id(1, 1, 1, 2, 1, 3, 1, 0, 0);
        check("alu_first_fwd", fwd_rs, 0);
        check("alu_first_stall", stall, 0);
        step();
        set_id(1, 3, 1, 4, 1, 6, 1, 0, 0);
        check("alu_fwd_rs_1", fwd_rs, 1);
        check("alu_fwd_rt_0", fwd_rt, 0);
        check("alu_stall", stall, 0);
        step();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        set_id(1, 3, 1, 6, 1, 0, 0, 0, 0);
        check("alu_fwd_rs_3", fwd_rs, 3);
        check("alu_fwd_rt_2", fwd_rt, 2);
        check("alu_late_stall", stall, 0);
        clear();

        // Load-use: lw $5 then add reading $5 twice.
        set_id(1, 1, 1, 0, 0, 5, 1, 1, 0);
        check("lw_stall", stall, 0);
        step();
        set_id(1, 5, 1, 5, 1, 7, 1, 0, 0);
        check("lu_stall", stall, 1);
        check("lu_fwd_rs", fwd_rs, 1);
        check("lu_flush", flush_if, 0);
        step();
        check("lu_released", stall, 0);
        check("lu_fwd_rs_2", fwd_rs, 2);
        check("lu_fwd_rt_2", fwd_rt, 2);
        set_id(1, 7, 1, 0, 0, 0, 0, 0, 0);
        check("lu_ex_bubble", fwd_rs, 0);
        set_id(1, 5, 1, 5, 1, 7, 1, 0, 0);
        step();
        set_id(1, 7, 1, 5, 1, 0, 0, 0, 0);
        check("lu_next_fwd_rs", fwd_rs, 1);
        check("lu_next_fwd_rt", fwd_rt, 3);
        check("lu_next_stall", stall, 0);
        clear();

        // Register 0 and unused operands.
        set_id(1, 1, 1, 0, 0, 0, 1, 1, 0);
        step();
        set_id(1, 0, 1, 0, 1, 0, 0, 0, 0);
        check("r0_stall", stall, 0);
        check("r0_fwd_rs", fwd_rs, 0);
        check("r0_fwd_rt", fwd_rt, 0);
        set_id(1, 1, 1, 0, 0, 8, 1, 1, 0);
        step();
        set_id(1, 8, 0, 8, 0, 0, 0, 0, 0);
        check("unused_stall", stall, 0);
        check("unused_fwd_rs", fwd_rs, 0);
        check("unused_fwd_rt", fwd_rt, 0);
        set_id(1, 1, 1, 8, 1, 0, 0, 0, 0);
        check("used_rt_stall", stall, 1);
        check("used_rt_fwd", fwd_rt, 1);
        set_id(0, 1, 1, 8, 1, 0, 0, 0, 0);
        check("bubble_no_stall", stall, 0);
        clear();

        // Youngest producer wins: $4 in stages 1 and 3.
        set_id(1, 1, 1, 0, 0, 4, 1, 0, 0);
        step();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        set_id(1, 1, 1, 0, 0, 4, 1, 0, 0);
        step();
        set_id(1, 4, 1, 0, 0, 0, 0, 0, 0);
        check("youngest_fwd_rs", fwd_rs, 1);
        clear();

        // Branch redirect: ready operands flush; a load-use redirect waits.
        set_id(1, 1, 1, 2, 1, 0, 0, 0, 1);
        check("br_flush", flush_if, 1);
        check("br_stall", stall, 0);
        step();
        set_id(1, 1, 1, 0, 0, 9, 1, 1, 0);
        check("br_lw_flush", flush_if, 0);
        step();
        set_id(1, 9, 1, 2, 1, 0, 0, 0, 1);
        check("br_lu_stall", stall, 1);
        check("br_lu_flush", flush_if, 0);
        advance = 1'b0;
        step();
        check("hold_stall", stall, 1);
        check("hold_fwd_rs", fwd_rs, 1);
        advance = 1'b1;
        step();
        check("br_after_stall", stall, 0);
        check("br_after_flush", flush_if, 1);
        check("br_after_fwd", fwd_rs, 2);
        step();
`ifdef HAZARD_STATS_EN
        check("stall_cnt", stall_cnt, 2);
        check("flush_cnt", flush_cnt, 2);
`endif
        clear();

        // Asynchronous reset between edges drops a live stall.
        set_id(1, 1, 1, 0, 0, 10, 1, 1, 0);
        step();
        set_id(1, 10, 1, 0, 0, 0, 0, 0, 0);
        check("pre_rst_stall", stall, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_stall", stall, 0);
        check("mid_rst_fwd", fwd_rs, 0);
`ifdef HAZARD_STATS_EN
        check("mid_rst_stall_cnt", stall_cnt, 0);
        check("mid_rst_flush_cnt", flush_cnt, 0);
`endif
        #1 rst = 1'b0;
        step();
        check("post_rst_stall", stall, 0);
        check("post_rst_fwd", fwd_rs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the stepped MIPS pipeline. It tracks in-flight destination registers across a configurable number of post-ID stages and picks a forwarding source per ID operand. It raises a load-use stall when the needed data is not yet available and flushes IF/ID on an ID-stage redirect. It replaces hard-wired EX/MEM/WB compare chains and the separate stall logic, and sits beside the ID stage, driven by the same step clock.

## Interface
- `AW`, 5: register address width; register 0 is hardwired zero.
- `STAGES`, 3: number of tracked post-ID stages; index 1 = EX … `STAGES` = WB; legal 2..7.
- `LOAD_READY`, 2: first stage index at which load data can be forwarded; legal 1..`STAGES`.
- `SELW`, 3: width of forward selects; must satisfy 2^`SELW` > `STAGES`.
- `clk` in 1: pipeline step clock.
- `rst` in 1: reset, asynchronous, active-high.
- `advance` in 1: pipeline step enable; scoreboard state changes only when high.
- `id_valid` in 1: ID holds a real instruction (0 = bubble).
- `id_rs`, `id_rt` in `AW`: source registers of the ID instruction.
- `id_rs_used`, `id_rt_used` in 1: the operand is actually read.
- `id_dst` in `AW`: destination register.
- `id_wr` in 1: the instruction writes `id_dst`.
- `id_load` in 1: the instruction is a load; its result is late.
- `id_redirect` in 1: J/JAL/JR or taken branch resolved in ID.
- `stall` out 1: hold PC and IF/ID; insert a bubble into EX.
- `flush_if` out 1: squash the IF/ID instruction.
- `fwd_rs`, `fwd_rt` out `SELW`: 0 = register file, k = result of stage k.
- `stall_cnt`, `flush_cnt` out 16: event counters; present only with `HAZARD_STATS_EN`.

## Operation
- The scoreboard is an array of `STAGES` entries, each holding {valid, dst, load}. Entry k mirrors the instruction in stage k.
- On a rising `clk` with `advance`=1:
  - Entry k moves to entry k+1, and entry `STAGES` retires.
  - Entry 1 loads {`id_valid & id_wr & (id_dst!=0) & ~stall`, `id_dst`, `id_load`}. A stalled ID instruction therefore enters as a bubble.
- With `advance`=0 all state holds. Outputs still track the inputs combinationally.
- Match rule: operand X (`rs`/`rt`) matches entry k when valid_k, dst_k==X, X!=0, and X is used. The lowest k wins, because it is the youngest producer.
- Forward select: `fwd_X` = winning k, or 0 if there is no match.
- Hazard rule: the winning entry is a load and k < `LOAD_READY`.
- `stall` = `id_valid` & hazard on rs or rt. Older entries are ignored once a younger one matches.
- `flush_if` = `id_valid & id_redirect & ~stall`. A redirect whose operands are not ready waits, and flushes on the cycle its stall clears.
- Both operands hazardous gives a single stall; it is not counted twice.
- A non-load producer is always forwardable from stage 1 onward. Stage-1 forwarding is a same-cycle ALU-result bypass.

## Timing
- `stall`, `flush_if` and `fwd_*` are combinational from the ID inputs and the registered scoreboard, with zero latency.
- Each load-use case with `LOAD_READY`=L and the consumer directly behind the load stalls L−1 steps, then forwards from stage L.
- Reset clears every valid bit and counter asynchronously. Outputs after reset: `stall`=0, `flush_if`=0 (with `id_valid`=0), `fwd_*`=0, counters 0.
- Reset asserted mid-stall drops the stall on the same edge. No stale entry survives.
- Entries shift with the same edge that captures IF/ID and ID/EX. No extra pipeline register exists.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `stall_cnt` increments on each `advance` edge with `stall`=1.
  - `flush_cnt` increments on each `advance` edge with `flush_if`=1.
  - Both saturate at 16'hFFFF and clear on `rst`.
- Not defined: both ports and counters are absent, and the module has no counter registers.

## Test plan
- ALU chain, defaults: `add $3` then `sub` reading $3 → `fwd_rs`=1, `stall`=0. Two steps later, a reader of $3 gets `fwd`=3.
- Load-use, `LOAD_READY`=2: `lw $5` then `add` reading $5 → `stall`=1 for exactly 1 step, then `fwd`=2, `stall`=0. The EX entry is a bubble.
- Register 0 and unused operands: `lw $0` followed by a reader of $0, or `id_rt_used`=0 with a matching rt → `stall`=0, `fwd`=0.
- Youngest wins: $4 written at stages 1 and 3 → `fwd_rs`=1.
- Branch redirect: `beq` with ready operands → `flush_if`=1. Redirect with a load-use hazard → `flush_if`=0 while `stall`=1, then `flush_if`=1 on the next step.
- Async reset mid-stall: assert `rst` between edges → `stall`=0 immediately and counters 0. With `HAZARD_STATS_EN`, 3 stalls and 1 flush yield `stall_cnt`=3, `flush_cnt`=1.
